rcvr_fifo: RTL and testbench
============================

// Module: rcvr_fifo
// PURPOSE
//  Parametrised serial packet receiver: hunts a 1-bit serial stream for a programmable header,
//  deserialises the following DATA_WIDTH-bit body (MSB first), pushes each word into an output FIFO.
//  Sits between the serial link pin logic and the consumer; consumer pops with reading.
//  Adds configurable header, body width and buffering, word count and drop-on-full overrun.
// PARAMETERS
//  HEAD_WIDTH    8        header length in bits (>=1)
//  HEAD_PATTERN  8'hA5    header value, first-received bit is MSB
//  DATA_WIDTH    8        body word width in bits (>=1)
//  FIFO_DEPTH    4        output words buffered (>=1, power of two)
// PORTS
//  clock     in   1                     rising-edge clock
//  reset     in   1                     synchronous, active-high reset
//  data_in   in   1                     serial data, one bit per clock
//  reading   in   1                     consumer pops head word this cycle (ignored when ready=0)
//  ready     out  1                     FIFO non-empty; data_out valid
//  overrun   out  1                     sticky: a completed word was dropped because FIFO was full
//  data_out  out  DATA_WIDTH            FIFO head word (first-word-fall-through)
//  count     out  $clog2(FIFO_DEPTH+1)  words currently held
// BEHAVIOUR
//  Reset: state=HUNT, history valid count=0, FIFO emptied; ready=0, overrun=0, count=0;
//   data_out don't-care while ready=0. Reset mid-packet discards the partial word.
//  HUNT: shift data_in into HEAD_WIDTH-bit history; valid count saturates at HEAD_WIDTH.
//   Match when valid count==HEAD_WIDTH and history==HEAD_PATTERN (incl. this cycle's bit);
//   overlapping/partial headers are found naturally (no fixed FSM path).
//   On match: -> BODY, bit counter=0, history valid count cleared.
//  BODY: bits arriving in the next DATA_WIDTH cycles shift into body register, MSB first.
//   On the DATA_WIDTH-th bit the word {body[DATA_WIDTH-2:0],data_in} completes; -> HUNT.
//   Body bits never contribute to header detection; hunt restarts empty.
//  Latency: last header bit in cycle N; body bits cycles N+1..N+DATA_WIDTH;
//   word visible, ready=1, in cycle N+DATA_WIDTH+1 (if FIFO was empty).
//  Push/pop same cycle: reading with ready=1 pops head at the clock edge.
//   Completion with FIFO full and reading=1 -> pop and push both happen, count unchanged, no overrun.
//   Completion with FIFO full and reading=0 -> word dropped, overrun set.
//  overrun: cleared on any cycle with reading=1 (unless set by the same-cycle rule above,
//   which cannot occur), else set on drop, else holds.
//  reading while empty: no effect on FIFO pointers or count; does clear overrun.
//  Pointers wrap modulo FIFO_DEPTH; count in 0..FIFO_DEPTH, never exceeds.
// STRUCTURE
//  rcvr_pkg (Verilog include): state encodings HUNT/BODY, width helper localparams
//   (CNT_W=$clog2(DATA_WIDTH), CNT_FIFO_W=$clog2(FIFO_DEPTH+1)).
//  Sub-module sync_fifo #(WIDTH,DEPTH): sync-reset FWFT FIFO with push, pop, full,
//   empty, count; rcvr_fifo owns the header hunt, deserialiser and overrun logic.
// TESTING  (defaults: HEAD 8'hA5, DATA_WIDTH 8, FIFO_DEPTH 4)
//  Send A5 then 3C -> ready=1 in cycle 17 after first header bit, data_out=8'h3C, count=1.
//  Send 0xA5A5 overlap prefix 1010_0101_0... e.g. bits 1101_0010_1 then body 81 -> header
//   found on true A5 alignment, data_out=8'h81.
//  Five packets, no reading -> count=4, words 1..4 retained in order, 5th dropped, overrun=1;
//   one reading pulse -> overrun=0, count=3, data_out=word 2.
//  FIFO full, 5th word completes in the same cycle as reading -> count stays 4, overrun=0,
//   new word at tail.
//  Assert reset in the middle of a body (bit 4) -> ready=0, count=0; next full packet
//   received cleanly.
//  Param sweep HEAD_WIDTH=4 pattern 4'h9, DATA_WIDTH=12, FIFO_DEPTH=2: 9 then 12'hABC ->
//   data_out=12'hABC.

Source files
------------

// File: rtl/rcvr_fifo_pkg.sv
// Shared types and width helpers for the serial packet receiver.
package rcvr_fifo_pkg;

    // Receiver phase: hunting for a header, or collecting body bits.
    typedef enum logic {
        HUNT = 1'b0,
        BODY = 1'b1
    } rcvr_state_t;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rcvr_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module rcvr_fifo_sync_fifo
    import rcvr_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = idx_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so any depth works, not only ones filling the pointer range.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a word when a pop frees a slot on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rcvr_fifo.sv
// Serial packet receiver: header hunt, MSB-first deserialiser, buffered output with overrun flag.
module rcvr_fifo
    import rcvr_fifo_pkg::*;
#(
    parameter int                    HEAD_WIDTH   = 8,
    parameter logic [HEAD_WIDTH-1:0] HEAD_PATTERN = 8'hA5,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    FIFO_DEPTH   = 4,
    localparam int CNT_FIFO_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  data_in,
    input  logic                  reading,
    output logic                  ready,
    output logic                  overrun,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_FIFO_W-1:0] count
);

    localparam int CNT_W  = idx_width(DATA_WIDTH);
    localparam int HCNT_W = idx_width(HEAD_WIDTH + 1);

    rcvr_state_t           state;
    rcvr_state_t           state_next;
    logic [HEAD_WIDTH-1:0] hist;
    logic [HEAD_WIDTH-1:0] hist_shift;
    logic [HCNT_W-1:0]     hist_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] body;
    logic [DATA_WIDTH-1:0] word;
    logic                  match;
    logic                  last_bit;
    logic                  full;
    logic                  empty;
    logic                  drop;

    // History and body including the bit arriving this cycle.
    assign hist_shift = HEAD_WIDTH'({hist, data_in});
    assign word       = DATA_WIDTH'({body, data_in});

    // Header seen only once enough bits have been collected since the hunt restarted.
    assign match    = (state == HUNT) && (hist_cnt >= HCNT_W'(HEAD_WIDTH - 1))
                      && (hist_shift == HEAD_PATTERN);
    assign last_bit = (state == BODY) && (bit_cnt == CNT_W'(DATA_WIDTH - 1));

    // A full FIFO only loses the word when the consumer is not popping on the same edge.
    assign drop  = last_bit && full && !reading;
    assign ready = !empty;

    // Phase register.
    always_ff @(posedge clock) begin
        if (reset) state <= HUNT;
        else       state <= state_next;
    end

    // Phase transitions: header found -> body, last body bit -> back to hunting.
    always_comb begin
        state_next = state;
        case (state)
            HUNT:    if (match)    state_next = BODY;
            BODY:    if (last_bit) state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    // Control counters: valid-history count and body bit position.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state == HUNT) begin
            if (match) begin
                hist_cnt <= '0;
                bit_cnt  <= '0;
            end else if (hist_cnt != HCNT_W'(HEAD_WIDTH)) begin
                hist_cnt <= hist_cnt + HCNT_W'(1);
            end
        end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Shift registers: history only moves while hunting, body only while in a packet.
    always_ff @(posedge clock) begin
        if (state == HUNT) hist <= hist_shift;
        else               body <= word;
    end

    // Sticky drop flag, cleared by any consumer read.
    always_ff @(posedge clock) begin
        if (reset)        overrun <= 1'b0;
        else if (reading) overrun <= 1'b0;
        else if (drop)    overrun <= 1'b1;
    end

    rcvr_fifo_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (last_bit),
        .pop   (reading),
        .wdata (word),
        .rdata (data_out),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_rcvr_fifo.sv
// Bench for rcvr_fifo: default-parameter instance checked every cycle against a queue model,
// plus a narrow-header / wide-body / shallow-FIFO instance checked with directed values.
module tb_rcvr_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        data_in = 1'b0;
    logic        reading = 1'b0;
    logic        ready;
    logic        overrun;
    logic [7:0]  data_out;
    logic [2:0]  count;

    logic        d2 = 1'b0;
    logic        ready2;
    logic        overrun2;
    logic [11:0] data_out2;
    logic [1:0]  count2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    rcvr_fifo dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .reading  (reading),
        .ready    (ready),
        .overrun  (overrun),
        .data_out (data_out),
        .count    (count)
    );

    rcvr_fifo #(
        .HEAD_WIDTH   (4),
        .HEAD_PATTERN (4'h9),
        .DATA_WIDTH   (12),
        .FIFO_DEPTH   (2)
    ) dut2 (
        .clock    (clock),
        .reset    (reset),
        .data_in  (d2),
        .reading  (1'b0),
        .ready    (ready2),
        .overrun  (overrun2),
        .data_out (data_out2),
        .count    (count2)
    );

    // Behavioural model of the default instance: last-8-bits window, body collector, word queue.
    bit         hq[$];
    bit         in_body = 1'b0;
    int         bcnt = 0;
    logic [7:0] acc = '0;
    logic [7:0] q[$];
    bit         ovr = 1'b0;

    function automatic logic [7:0] window_value();
        logic [7:0] v = '0;
        foreach (hq[i]) v = {v[6:0], hq[i]};
        return v;
    endfunction

    task automatic model_step(input bit d, input bit rd, input bit rst);
        bit         have_word = 1'b0;
        logic [7:0] w = '0;
        if (rst) begin
            hq.delete();
            q.delete();
            in_body = 1'b0;
            bcnt    = 0;
            ovr     = 1'b0;
            return;
        end
        if (in_body) begin
            acc = {acc[6:0], d};
            bcnt++;
            if (bcnt == 8) begin
                have_word = 1'b1;
                w         = acc;
                in_body   = 1'b0;
                hq.delete();
            end
        end else begin
            hq.push_back(d);
            if (hq.size() > 8) void'(hq.pop_front());
            if (hq.size() == 8 && window_value() == 8'hA5) begin
                in_body = 1'b1;
                bcnt    = 0;
                hq.delete();
            end
        end
        if (rd) begin
            if (q.size() > 0) void'(q.pop_front());
            ovr = 1'b0;
        end
        if (have_word) begin
            if (q.size() < 4) q.push_back(w);
            else              ovr = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the default instance against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_ready",   32'(ready),   32'(q.size() != 0));
            chk("model_count",   32'(count),   32'(q.size()));
            chk("model_overrun", 32'(overrun), 32'(ovr));
            if (q.size() != 0) chk("model_data_out", 32'(data_out), 32'(q[0]));
        end
    end

    task automatic cyc(input bit d, input bit rd, input bit rst);
        data_in = d;
        reading = rd;
        reset   = rst;
        @(posedge clock);
        model_step(d, rd, rst);
        @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b, input bit rd_last);
        for (int i = 7; i >= 0; i--) cyc(b[i], (i == 0) ? rd_last : 1'b0, 1'b0);
    endtask

    task automatic packet(input logic [7:0] b, input bit rd_last);
        send(8'hA5, 1'b0);
        send(b, rd_last);
    endtask

    initial begin
        logic [7:0]  b;
        logic [8:0]  pre;
        logic [15:0] s2;

        // Reset state
        cyc(1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        chk("reset_ready",   32'(ready),   32'd0);
        chk("reset_count",   32'(count),   32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);

        // A5 then 3C: word appears exactly after the 16th bit
        send(8'hA5, 1'b0);
        b = 8'h3C;
        for (int i = 7; i >= 1; i--) cyc(b[i], 1'b0, 1'b0);
        chk("latency_not_yet", 32'(ready), 32'd0);
        cyc(b[0], 1'b0, 1'b0);
        chk("first_ready", 32'(ready),    32'd1);
        chk("first_data",  32'(data_out), 32'h3C);
        chk("first_count", 32'(count),    32'd1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("first_popped", 32'(ready), 32'd0);

        // Overlapping prefix 1101_0010_1 ends on the true A5 alignment
        pre = 9'b1_1010_0101;
        for (int i = 8; i >= 0; i--) cyc(pre[i], 1'b0, 1'b0);
        send(8'h81, 1'b0);
        chk("overlap_data",  32'(data_out), 32'h81);
        chk("overlap_count", 32'(count),    32'd1);
        cyc(1'b0, 1'b1, 1'b0);

        // Five packets, no reading: fifth dropped
        for (int k = 1; k <= 5; k++) packet(8'(k), 1'b0);
        chk("ovf_count",   32'(count),    32'd4);
        chk("ovf_overrun", 32'(overrun),  32'd1);
        chk("ovf_head",    32'(data_out), 32'h01);
        cyc(1'b0, 1'b1, 1'b0);
        chk("ovf_pop_overrun", 32'(overrun),  32'd0);
        chk("ovf_pop_count",   32'(count),    32'd3);
        chk("ovf_pop_head",    32'(data_out), 32'h02);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0);
        chk("drained_count", 32'(count), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("read_empty_count", 32'(count), 32'd0);

        // Full FIFO, fifth word completes on a reading cycle
        packet(8'h11, 1'b0);
        packet(8'h22, 1'b0);
        packet(8'h33, 1'b0);
        packet(8'h44, 1'b0);
        packet(8'h55, 1'b1);
        chk("full_rw_count",   32'(count),    32'd4);
        chk("full_rw_overrun", 32'(overrun),  32'd0);
        chk("full_rw_head",    32'(data_out), 32'h22);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0);
        chk("full_rw_tail",  32'(data_out), 32'h55);
        chk("full_rw_count1", 32'(count),   32'd1);
        cyc(1'b0, 1'b1, 1'b0);

        // Reset in the middle of a body
        packet(8'h77, 1'b0);
        send(8'hA5, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("midreset_ready", 32'(ready), 32'd0);
        chk("midreset_count", 32'(count), 32'd0);
        packet(8'h5A, 1'b0);
        chk("after_reset_data",  32'(data_out), 32'h5A);
        chk("after_reset_count", 32'(count),    32'd1);
        cyc(1'b0, 1'b1, 1'b0);

        // Parameter sweep instance: header 4'h9, body 12'hABC
        s2 = {4'h9, 12'hABC};
        for (int i = 15; i >= 1; i--) begin
            d2 = s2[i];
            cyc(1'b0, 1'b0, 1'b0);
        end
        chk("p2_not_yet", 32'(ready2), 32'd0);
        d2 = s2[0];
        cyc(1'b0, 1'b0, 1'b0);
        d2 = 1'b0;
        chk("p2_ready",   32'(ready2),    32'd1);
        chk("p2_data",    32'(data_out2), 32'hABC);
        chk("p2_count",   32'(count2),    32'd1);
        chk("p2_overrun", 32'(overrun2),  32'd0);
        cyc(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
